// File: rtl/mem_access_unit.sv
// MEM stage: data memory handshake with wait/timeout FSM,
// branch resolution and MEM/WB pipeline register.
// Optional feature: MEM_ALIGN_CHECK_EN (misaligned access trap).
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        MEM_RegWrite,
    input  logic        MEM_MemtoReg,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic        MEM_Branch,
    input  logic [31:0] MEM_BranchAddr,
    input  logic        MEM_Zero,
    input  logic [31:0] MEM_ALUResult,
    input  logic [31:0] MEM_ReadData2,
    input  logic [4:0]  MEM_WriteReg,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        mem_stall,
    output logic        PCSrc,
    output logic [31:0] BranchTarget,
    output logic        flush_out,
    output logic        WB_RegWrite,
    output logic        WB_MemtoReg,
    output logic [31:0] WB_ReadData,
    output logic [31:0] WB_ALUResult,
    output logic [4:0]  WB_WriteReg,
    output logic        bus_err
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic        align_err
`endif
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       access;
    logic       misaligned;
    logic       acc_ok;
    logic       timeout_now;
    logic       rd_done;

    assign access = MEM_MemRead | MEM_MemWrite;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = access & (MEM_ALUResult[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign acc_ok = access & ~misaligned;

    assign dmem_req   = ((state == IDLE) & acc_ok) | (state == WAIT);
    assign dmem_we    = MEM_MemWrite;
    assign dmem_addr  = MEM_ALUResult;
    assign dmem_wdata = MEM_ReadData2;

    assign timeout_now = (state == WAIT) & ~dmem_ack
                       & (wait_cnt == CNT_LAST);

    assign mem_stall = dmem_req & ~dmem_ack & ~timeout_now;

    // read+write together is a write, so no load data captured
    assign rd_done = dmem_req & dmem_ack
                   & MEM_MemRead & ~MEM_MemWrite;

    assign PCSrc        = MEM_Branch & MEM_Zero;
    assign BranchTarget = MEM_BranchAddr;
    assign flush_out    = PCSrc;

    // Handshake FSM: wait counter and sticky timeout flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
            bus_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc_ok && !dmem_ack) begin
                        state    <= WAIT;
                        wait_cnt <= 8'd1;
                    end
                end
                WAIT: begin
                    if (dmem_ack) begin
                        state    <= IDLE;
                        wait_cnt <= 8'd0;
                    end else if (timeout_now) begin
                        state    <= IDLE;
                        wait_cnt <= 8'd0;
                        bus_err  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    wait_cnt <= 8'd0;
                end
            endcase
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    // Sticky misaligned-access flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            align_err <= 1'b0;
        end else if (misaligned) begin
            align_err <= 1'b1;
        end
    end
`endif

    // MEM/WB register: advance, or bubble on stall/abort
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            WB_RegWrite  <= 1'b0;
            WB_MemtoReg  <= 1'b0;
            WB_ReadData  <= 32'd0;
            WB_ALUResult <= 32'd0;
            WB_WriteReg  <= 5'd0;
        end else if (mem_stall) begin
            WB_RegWrite <= 1'b0;
            WB_MemtoReg <= 1'b0;
        end else if (timeout_now || misaligned) begin
            WB_RegWrite  <= 1'b0;
            WB_MemtoReg  <= 1'b0;
            WB_ALUResult <= MEM_ALUResult;
            WB_WriteReg  <= MEM_WriteReg;
        end else begin
            WB_RegWrite  <= MEM_RegWrite;
            WB_MemtoReg  <= MEM_MemtoReg;
            WB_ALUResult <= MEM_ALUResult;
            WB_WriteReg  <= MEM_WriteReg;
            if (rd_done) begin
                WB_ReadData <= dmem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
// Build with +define+MEM_ALIGN_CHECK_EN to cover alignment trap.
module tb_mem_access_unit;

    logic        clk;
    logic        reset_n;
    logic        MEM_RegWrite, MEM_MemtoReg;
    logic        MEM_MemRead, MEM_MemWrite, MEM_Branch;
    logic [31:0] MEM_BranchAddr;
    logic        MEM_Zero;
    logic [31:0] MEM_ALUResult, MEM_ReadData2;
    logic [4:0]  MEM_WriteReg;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack, mem_stall, PCSrc, flush_out;
    logic [31:0] BranchTarget;
    logic        WB_RegWrite, WB_MemtoReg;
    logic [31:0] WB_ReadData, WB_ALUResult;
    logic [4:0]  WB_WriteReg;
    logic        bus_err;
`ifdef MEM_ALIGN_CHECK_EN
    logic        align_err;
`endif

    int errors = 0;
    int checks = 0;
    int n;

    mem_access_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .MEM_RegWrite(MEM_RegWrite), .MEM_MemtoReg(MEM_MemtoReg),
        .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
        .MEM_Branch(MEM_Branch), .MEM_BranchAddr(MEM_BranchAddr),
        .MEM_Zero(MEM_Zero), .MEM_ALUResult(MEM_ALUResult),
        .MEM_ReadData2(MEM_ReadData2), .MEM_WriteReg(MEM_WriteReg),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .mem_stall(mem_stall), .PCSrc(PCSrc),
        .BranchTarget(BranchTarget), .flush_out(flush_out),
        .WB_RegWrite(WB_RegWrite), .WB_MemtoReg(WB_MemtoReg),
        .WB_ReadData(WB_ReadData), .WB_ALUResult(WB_ALUResult),
        .WB_WriteReg(WB_WriteReg), .bus_err(bus_err)
`ifdef MEM_ALIGN_CHECK_EN
        , .align_err(align_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h",
                     tag, got, exp);
        end
    endtask

    task automatic clear_ctl();
        MEM_RegWrite   = 1'b0;
        MEM_MemtoReg   = 1'b0;
        MEM_MemRead    = 1'b0;
        MEM_MemWrite   = 1'b0;
        MEM_Branch     = 1'b0;
        MEM_Zero       = 1'b0;
        MEM_BranchAddr = 32'd0;
        MEM_ALUResult  = 32'd0;
        MEM_ReadData2  = 32'd0;
        MEM_WriteReg   = 5'd0;
        dmem_ack       = 1'b0;
    endtask

    initial begin
        clear_ctl();
        dmem_rdata = 32'd0;
        reset_n    = 1'b0;
        #2;
        check("rst_wb_rw", WB_RegWrite, 0);
        check("rst_wb_rd", WB_ReadData, 0);
        check("rst_bus_err", bus_err, 0);
        check("rst_req", dmem_req, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // zero-wait load
        @(negedge clk);
        MEM_MemRead   = 1'b1;
        MEM_MemtoReg  = 1'b1;
        MEM_RegWrite  = 1'b1;
        MEM_ALUResult = 32'h10;
        MEM_WriteReg  = 5'd5;
        dmem_ack      = 1'b1;
        dmem_rdata    = 32'hDEADBEEF;
        #1;
        check("ld_req", dmem_req, 1);
        check("ld_stall", mem_stall, 0);
        check("ld_addr", dmem_addr, 32'h10);
        @(posedge clk); #1;
        check("ld_wb_rd", WB_ReadData, 32'hDEADBEEF);
        check("ld_wb_rw", WB_RegWrite, 1);
        check("ld_wb_m2r", WB_MemtoReg, 1);
        check("ld_wb_wr", WB_WriteReg, 5);

        // store acked after 3 wait cycles
        @(negedge clk);
        clear_ctl();
        MEM_MemWrite  = 1'b1;
        MEM_RegWrite  = 1'b1;
        MEM_ALUResult = 32'h20;
        MEM_ReadData2 = 32'h12345678;
        MEM_WriteReg  = 5'd7;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("st_stall", mem_stall, 1);
            check("st_we", dmem_we, 1);
            @(posedge clk); #1;
            check("st_bubble", WB_RegWrite, 0);
            @(negedge clk);
        end
        check("st_hold_alu", WB_ALUResult, 32'h10);
        check("st_wdata", dmem_wdata, 32'h12345678);
        dmem_ack = 1'b1;
        #1;
        check("st_done_stall", mem_stall, 0);
        check("st_done_we", dmem_we, 1);
        @(posedge clk); #1;
        check("st_wb_rw", WB_RegWrite, 1);
        check("st_wb_alu", WB_ALUResult, 32'h20);
        check("st_rd_hold", WB_ReadData, 32'hDEADBEEF);

        // branch taken / not taken, ack ignored without req
        @(negedge clk);
        clear_ctl();
        MEM_Branch     = 1'b1;
        MEM_Zero       = 1'b1;
        MEM_BranchAddr = 32'h40;
        dmem_ack       = 1'b1;
        dmem_rdata     = 32'h55555555;
        #1;
        check("br_pcsrc", PCSrc, 1);
        check("br_flush", flush_out, 1);
        check("br_target", BranchTarget, 32'h40);
        check("noreq_req", dmem_req, 0);
        check("noreq_stall", mem_stall, 0);
        MEM_Zero = 1'b0;
        #1;
        check("br_nt_pcsrc", PCSrc, 0);
        check("br_nt_flush", flush_out, 0);
        @(posedge clk); #1;
        check("noreq_rd_hold", WB_ReadData, 32'hDEADBEEF);

        // read+write together behaves as write
        @(negedge clk);
        clear_ctl();
        MEM_MemRead   = 1'b1;
        MEM_MemWrite  = 1'b1;
        MEM_ALUResult = 32'h30;
        dmem_ack      = 1'b1;
        dmem_rdata    = 32'hAAAA0000;
        #1;
        check("rw_we", dmem_we, 1);
        @(posedge clk); #1;
        check("rw_rd_hold", WB_ReadData, 32'hDEADBEEF);

        // timeout on read with no ack
        @(negedge clk);
        clear_ctl();
        MEM_MemRead   = 1'b1;
        MEM_RegWrite  = 1'b1;
        MEM_MemtoReg  = 1'b1;
        MEM_ALUResult = 32'h44;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!mem_stall) break;
            n++;
            @(negedge clk);
        end
        check("to_stall_cycles", n, 15);
        check("to_pre_err", bus_err, 0);
        @(posedge clk); #1;
        check("to_bus_err", bus_err, 1);
        check("to_bubble", WB_RegWrite, 0);
        @(negedge clk);
        clear_ctl();
        #1;
        check("to_idle_req", dmem_req, 0);
        @(posedge clk); #1;
        check("to_sticky", bus_err, 1);

        // reset in the 2nd WAIT cycle
        @(negedge clk);
        MEM_MemRead  = 1'b1;
        MEM_RegWrite = 1'b1;
        MEM_ALUResult = 32'h50;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("rw2_req", dmem_req, 1);
        reset_n = 1'b0;
        #1;
        check("rs_bus_err", bus_err, 0);
        check("rs_wb_rd", WB_ReadData, 0);
        check("rs_wb_alu", WB_ALUResult, 0);
        clear_ctl();
        #1;
        check("rs_req_drop", dmem_req, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        MEM_MemRead   = 1'b1;
        MEM_RegWrite  = 1'b1;
        MEM_ALUResult = 32'h60;
        dmem_ack      = 1'b1;
        dmem_rdata    = 32'hCAFEF00D;
        #1;
        check("rs_next_stall", mem_stall, 0);
        @(posedge clk); #1;
        check("rs_next_rd", WB_ReadData, 32'hCAFEF00D);

`ifdef MEM_ALIGN_CHECK_EN
        // misaligned load trapped
        @(negedge clk);
        clear_ctl();
        MEM_MemRead   = 1'b1;
        MEM_RegWrite  = 1'b1;
        MEM_ALUResult = 32'h13;
        #1;
        check("al_req", dmem_req, 0);
        check("al_stall", mem_stall, 0);
        @(posedge clk); #1;
        check("al_err", align_err, 1);
        check("al_bubble", WB_RegWrite, 0);
`endif

        @(negedge clk);
        clear_ctl();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
